// File: rtl/ad7606_ctrl.sv
// AD7606 parallel-interface sequencer: power-up RESET pulse, CONVST pulse,
// BUSY handshake (with timeout), then one CS-low burst of RD strobes that
// captures NCHAN words and tags each with its channel index.
// Ports:
//   clk_i, reset_n_i          clock, async active-low reset
//   start_i, os_i             frame trigger and oversampling select (latched at start)
//   adc_reset_o, os_o         ADC RESET and OS[2:0] pins
//   convst_o, cs_n_o, rd_n_o  ADC conversion/read control pins
//   busy_i, frstdata_i, db_i  ADC status and data bus
//   sample_o, chan_o          captured word and its channel index
//   sample_valid_o            one-cycle strobe qualifying sample_o/chan_o
//   frame_done_o              one-cycle strobe after the last channel
//   ready_o                   high while idle (start_i accepted)
//   err_o                     sticky: [0] busy timeout, [1] FRSTDATA misalignment
module ad7606_ctrl #(
    parameter int unsigned NCHAN       = 8,
    parameter int unsigned ADCRST_CYC  = 4,
    parameter int unsigned CONV_LO_CYC = 2,
    parameter int unsigned RD_LO_CYC   = 3,
    parameter int unsigned RD_HI_CYC   = 2,
    parameter int unsigned BUSY_TO_CYC = 40000
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic [2:0]  os_i,
    output logic        adc_reset_o,
    output logic [2:0]  os_o,
    output logic        convst_o,
    output logic        cs_n_o,
    output logic        rd_n_o,
    input  logic        busy_i,
    input  logic        frstdata_i,
    input  logic [15:0] db_i,
    output logic [15:0] sample_o,
    output logic [2:0]  chan_o,
    output logic        sample_valid_o,
    output logic        frame_done_o,
    output logic        ready_o,
    output logic [1:0]  err_o
);

    localparam int unsigned MAX_A   = (ADCRST_CYC > CONV_LO_CYC) ? ADCRST_CYC : CONV_LO_CYC;
    localparam int unsigned MAX_B   = (RD_LO_CYC > RD_HI_CYC) ? RD_LO_CYC : RD_HI_CYC;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TO_W    = $clog2(BUSY_TO_CYC + 1);

    typedef enum logic [2:0] {
        S_ADCRST, S_IDLE, S_CONV_LO, S_WAIT_HI, S_WAIT_LO, S_RD_LO, S_RD_HI, S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [TO_W-1:0]    tcnt, tcnt_nx;
    logic [2:0]         ch, ch_nx;
    logic               busy_m, busy_s;

    logic               adc_reset_nx, convst_nx, cs_n_nx, rd_n_nx;
    logic               valid_nx, done_nx, ready_nx;
    logic [2:0]         os_nx, chan_nx;
    logic [15:0]        sample_nx;
    logic [1:0]         err_nx;

    logic adcrst_end, conv_end, rdlo_end, rdhi_end, last_ch, timeout, timed;

    assign adcrst_end = (cnt == CNT_W'(ADCRST_CYC - 1));
    assign conv_end   = (cnt == CNT_W'(CONV_LO_CYC - 1));
    assign rdlo_end   = (cnt == CNT_W'(RD_LO_CYC - 1));
    assign rdhi_end   = (cnt == CNT_W'(RD_HI_CYC - 1));
    assign last_ch    = (ch == 3'(NCHAN - 1));
    assign timeout    = (tcnt == TO_W'(BUSY_TO_CYC - 1));
    assign timed      = (state inside {S_ADCRST, S_CONV_LO, S_RD_LO, S_RD_HI});

    // BUSY is asynchronous to clk_i
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_m <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            busy_m <= busy_i;
            busy_s <= busy_m;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= S_ADCRST;
        else            state <= state_nx;
    end

    // Next-state logic; a busy edge wins over a coincident timeout
    always_comb begin
        state_nx = state;
        case (state)
            S_ADCRST:  if (adcrst_end) state_nx = S_IDLE;
            S_IDLE:    if (start_i) state_nx = S_CONV_LO;
            S_CONV_LO: if (conv_end) state_nx = S_WAIT_HI;
            S_WAIT_HI: begin
                if (busy_s)       state_nx = S_WAIT_LO;
                else if (timeout) state_nx = S_IDLE;
            end
            S_WAIT_LO: begin
                if (!busy_s)      state_nx = S_RD_LO;
                else if (timeout) state_nx = S_IDLE;
            end
            S_RD_LO:   if (rdlo_end) state_nx = S_RD_HI;
            S_RD_HI:   if (rdhi_end) state_nx = last_ch ? S_DONE : S_RD_LO;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_ADCRST;
        endcase
    end

    // Output / datapath next values (registered below)
    always_comb begin
        cnt_nx       = (timed && state_nx == state) ? CNT_W'(cnt + CNT_W'(1)) : '0;
        tcnt_nx      = (state == S_WAIT_HI || state == S_WAIT_LO) ? TO_W'(tcnt + TO_W'(1)) : '0;
        ch_nx        = ch;
        adc_reset_nx = adc_reset_o;
        os_nx        = os_o;
        convst_nx    = convst_o;
        cs_n_nx      = cs_n_o;
        rd_n_nx      = rd_n_o;
        sample_nx    = sample_o;
        chan_nx      = chan_o;
        valid_nx     = 1'b0;
        done_nx      = 1'b0;
        ready_nx     = ready_o;
        err_nx       = err_o;
        case (state)
            S_ADCRST: if (adcrst_end) begin
                adc_reset_nx = 1'b0;
                ready_nx     = 1'b1;
            end
            S_IDLE: if (start_i) begin
                os_nx     = os_i;
                err_nx    = 2'b00;
                convst_nx = 1'b0;
                ready_nx  = 1'b0;
            end
            S_CONV_LO: if (conv_end) convst_nx = 1'b1;
            S_WAIT_HI: if (!busy_s && timeout) begin
                err_nx[0] = 1'b1;
                cs_n_nx   = 1'b1;
                rd_n_nx   = 1'b1;
                ready_nx  = 1'b1;
            end
            S_WAIT_LO: begin
                if (!busy_s) begin
                    cs_n_nx = 1'b0;
                    rd_n_nx = 1'b0;
                    ch_nx   = 3'd0;
                end else if (timeout) begin
                    err_nx[0] = 1'b1;
                    cs_n_nx   = 1'b1;
                    rd_n_nx   = 1'b1;
                    ready_nx  = 1'b1;
                end
            end
            // Capture on the last RD-low cycle; FRSTDATA must flag only channel 0
            S_RD_LO: if (rdlo_end) begin
                sample_nx = db_i;
                chan_nx   = ch;
                valid_nx  = 1'b1;
                rd_n_nx   = 1'b1;
                if (frstdata_i != (ch == 3'd0)) err_nx[1] = 1'b1;
            end
            S_RD_HI: if (rdhi_end) begin
                if (last_ch) begin
                    cs_n_nx = 1'b1;
                    done_nx = 1'b1;
                end else begin
                    ch_nx   = 3'(ch + 3'd1);
                    rd_n_nx = 1'b0;
                end
            end
            S_DONE: ready_nx = 1'b1;
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt            <= '0;
            tcnt           <= '0;
            ch             <= 3'd0;
            adc_reset_o    <= 1'b1;
            os_o           <= 3'd0;
            convst_o       <= 1'b1;
            cs_n_o         <= 1'b1;
            rd_n_o         <= 1'b1;
            sample_o       <= 16'd0;
            chan_o         <= 3'd0;
            sample_valid_o <= 1'b0;
            frame_done_o   <= 1'b0;
            ready_o        <= 1'b0;
            err_o          <= 2'b00;
        end else begin
            cnt            <= cnt_nx;
            tcnt           <= tcnt_nx;
            ch             <= ch_nx;
            adc_reset_o    <= adc_reset_nx;
            os_o           <= os_nx;
            convst_o       <= convst_nx;
            cs_n_o         <= cs_n_nx;
            rd_n_o         <= rd_n_nx;
            sample_o       <= sample_nx;
            chan_o         <= chan_nx;
            sample_valid_o <= valid_nx;
            frame_done_o   <= done_nx;
            ready_o        <= ready_nx;
            err_o          <= err_nx;
        end
    end

endmodule

// File: tb/tb_ad7606_ctrl.sv
// Bench for ad7606_ctrl: behavioural ADC (BUSY pulse after CONVST, one random
// word per RD falling edge) and a per-frame expectation built from the word list.
module tb_ad7606_ctrl;

    localparam int unsigned NCH  = 8;
    localparam int unsigned ARST = 4;
    localparam int unsigned CLO  = 2;
    localparam int unsigned RLO  = 3;
    localparam int unsigned RHI  = 2;
    localparam int unsigned TO   = 300;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  os_i = 3'd0;
    logic        busy_i = 1'b0;
    logic        frstdata_i = 1'b0;
    logic [15:0] db_i = 16'd0;
    logic        adc_reset_o, convst_o, cs_n_o, rd_n_o;
    logic [2:0]  os_o, chan_o;
    logic [15:0] sample_o;
    logic        sample_valid_o, frame_done_o, ready_o;
    logic [1:0]  err_o;

    ad7606_ctrl #(
        .NCHAN(NCH), .ADCRST_CYC(ARST), .CONV_LO_CYC(CLO),
        .RD_LO_CYC(RLO), .RD_HI_CYC(RHI), .BUSY_TO_CYC(TO)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .os_i(os_i),
        .adc_reset_o(adc_reset_o), .os_o(os_o), .convst_o(convst_o),
        .cs_n_o(cs_n_o), .rd_n_o(rd_n_o), .busy_i(busy_i),
        .frstdata_i(frstdata_i), .db_i(db_i), .sample_o(sample_o),
        .chan_o(chan_o), .sample_valid_o(sample_valid_o),
        .frame_done_o(frame_done_o), .ready_o(ready_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic [2:0] chan; logic [15:0] data; } smp_t;

    logic [15:0] words [NCH];
    bit          bad_first_g = 1'b0;
    bit          busy_en_g   = 1'b0;
    int          rd_falls    = 0;
    int          rd_base     = 0;
    smp_t        got [$];
    int          done_cnt    = 0;

    // Frame results gathered by run_frame
    int f_base, f_done_base, f_conv_lo, f_rd_lo, f_to_cyc;
    bit f_os_ok, f_order_ok;

    // ADC model: BUSY high for a random stretch after each CONVST rise
    always @(posedge convst_o) begin
        int blen;
        if (busy_en_g) begin
            blen = int'($urandom_range(60, 20));
            #3 busy_i = 1'b1;
            repeat (blen) @(posedge clk_i);
            #3 busy_i = 1'b0;
        end
    end

    // ADC model: next word on each RD fall, bus garbage while RD high
    always @(rd_n_o) begin
        int k;
        if (rd_n_o === 1'b0) begin
            k = rd_falls - rd_base;
            db_i = (k >= 0 && k < int'(NCH)) ? words[k] : 16'($urandom);
            frstdata_i = (k == 0) ? ~bad_first_g : 1'b0;
            rd_falls = rd_falls + 1;
        end else begin
            db_i = 16'($urandom);
            frstdata_i = 1'($urandom);
        end
    end

    // Collect every strobe the DUT produces
    always @(negedge clk_i) begin
        smp_t s;
        if (sample_valid_o === 1'b1) begin
            s.chan = chan_o;
            s.data = sample_o;
            got.push_back(s);
        end
        if (frame_done_o === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic wait_adcrst(output int n);
        n = 0;
        while (adc_reset_o === 1'b1 && n < 50) begin
            @(posedge clk_i);
            #1;
            n++;
        end
    endtask

    task automatic prep_frame(input bit bad_first, input bit busy_en);
        for (int k = 0; k < int'(NCH); k++) words[k] = 16'($urandom);
        bad_first_g = bad_first;
        busy_en_g   = busy_en;
        rd_base     = rd_falls;
        f_base      = got.size();
        f_done_base = done_cnt;
    endtask

    task automatic run_frame(input logic [2:0] os, input bit bad_first, input bit busy_en,
                             input bit hold_start, input bit scramble_os);
        int  n;
        int  rise;
        bit  finished;
        n = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        prep_frame(bad_first, busy_en);
        @(negedge clk_i);
        os_i    = os;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i   = hold_start;
        f_conv_lo = 0;
        f_rd_lo   = 0;
        f_os_ok   = 1'b1;
        f_order_ok = 1'b1;
        f_to_cyc  = -1;
        rise      = -1;
        finished  = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if (convst_o === 1'b0) f_conv_lo++;
            if (rd_n_o === 1'b0) f_rd_lo++;
            if (os_o !== os) f_os_ok = 1'b0;
            if (rd_n_o === 1'b0 && busy_i === 1'b1) f_order_ok = 1'b0;
            if (rise < 0 && f_conv_lo > 0 && convst_o === 1'b1) rise = c;
            if (ready_o === 1'b1) begin
                finished = 1'b1;
                f_to_cyc = c - rise;
                break;
            end
            if (scramble_os) os_i = 3'($urandom);
            @(negedge clk_i);
        end
        start_i = 1'b0;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL frame_end: ready_o never returned (ready_o=%b) required 1", ready_o);
        end
    endtask

    task automatic test_reset();
        int n;
        reset_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        total++;
        if ({adc_reset_o, convst_o, cs_n_o, rd_n_o} !== 4'b1111) begin
            bad++;
            $display("FAIL rst_pins: got %b required 1111", {adc_reset_o, convst_o, cs_n_o, rd_n_o});
        end
        total++;
        if ({ready_o, sample_valid_o, frame_done_o, err_o, os_o, chan_o, sample_o} !== '0) begin
            bad++;
            $display("FAIL rst_outs: ready=%b valid=%b done=%b err=%b os=%0d chan=%0d sample=%h required all 0",
                     ready_o, sample_valid_o, frame_done_o, err_o, os_o, chan_o, sample_o);
        end
        reset_n_i = 1'b1;
        wait_adcrst(n);
        total++;
        if (n != int'(ARST)) begin
            bad++;
            $display("FAIL adcrst_width: got %0d cycles required %0d", n, ARST);
        end
        total++;
        if ({ready_o, convst_o, cs_n_o} !== 3'b111) begin
            bad++;
            $display("FAIL post_rst: ready/convst/cs_n=%b required 111", {ready_o, convst_o, cs_n_o});
        end
    endtask

    task automatic test_frames();
        logic [2:0] os;
        for (int f = 0; f < 4; f++) begin
            os = (f == 0) ? 3'd0 : 3'($urandom);
            run_frame(os, 1'b0, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < int'(NCH); k++) begin
                total++;
                if (got.size() <= f_base + k) begin
                    bad++;
                    $display("FAIL frame%0d_ch%0d: sample missing, required %h", f, k, words[k]);
                end else if (got[f_base + k].chan !== 3'(k) || got[f_base + k].data !== words[k]) begin
                    bad++;
                    $display("FAIL frame%0d_ch%0d: got chan=%0d data=%h required chan=%0d data=%h",
                             f, k, got[f_base + k].chan, got[f_base + k].data, k, words[k]);
                end
            end
            total++;
            if (got.size() - f_base != int'(NCH) || done_cnt - f_done_base != 1) begin
                bad++;
                $display("FAIL frame%0d_counts: samples=%0d done=%0d required %0d and 1",
                         f, got.size() - f_base, done_cnt - f_done_base, NCH);
            end
            total++;
            if (err_o !== 2'b00 || os_o !== os) begin
                bad++;
                $display("FAIL frame%0d_status: err=%b os=%0d required 00 and %0d", f, err_o, os_o, os);
            end
            total++;
            if (f_conv_lo != int'(CLO) || f_rd_lo != int'(NCH * RLO)) begin
                bad++;
                $display("FAIL frame%0d_widths: convst_lo=%0d rd_lo=%0d required %0d and %0d",
                         f, f_conv_lo, f_rd_lo, CLO, NCH * RLO);
            end
        end
    endtask

    task automatic test_os_hold();
        run_frame(3'b011, 1'b0, 1'b1, 1'b0, 1'b1);
        total++;
        if (!f_os_ok || os_o !== 3'b011) begin
            bad++;
            $display("FAIL os_hold: os_o=%0d stable=%0d required 3 stable=1", os_o, f_os_ok);
        end
        total++;
        if (!f_order_ok) begin
            bad++;
            $display("FAIL rd_after_busy: rd_n_o low while busy_i high, required none");
        end
        total++;
        if (got.size() - f_base != int'(NCH)) begin
            bad++;
            $display("FAIL os_frame_samples: got %0d required %0d", got.size() - f_base, NCH);
        end
    endtask

    task automatic test_timeout();
        run_frame(3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (err_o !== 2'b01) begin
            bad++;
            $display("FAIL to_err: got %b required 01", err_o);
        end
        total++;
        if (got.size() - f_base != 0 || done_cnt - f_done_base != 0) begin
            bad++;
            $display("FAIL to_outputs: samples=%0d done=%0d required 0 and 0",
                     got.size() - f_base, done_cnt - f_done_base);
        end
        total++;
        if (f_to_cyc != int'(TO)) begin
            bad++;
            $display("FAIL to_cycles: got %0d required %0d", f_to_cyc, TO);
        end
        total++;
        if ({cs_n_o, rd_n_o, convst_o} !== 3'b111) begin
            bad++;
            $display("FAIL to_pins: cs_n/rd_n/convst=%b required 111", {cs_n_o, rd_n_o, convst_o});
        end
        run_frame(3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (err_o !== 2'b00 || got.size() - f_base != int'(NCH)) begin
            bad++;
            $display("FAIL to_recover: err=%b samples=%0d required 00 and %0d",
                     err_o, got.size() - f_base, NCH);
        end
    endtask

    task automatic test_frstdata();
        run_frame(3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (err_o !== 2'b10) begin
            bad++;
            $display("FAIL frst_err: got %b required 10", err_o);
        end
        total++;
        if (got.size() - f_base != int'(NCH) || done_cnt - f_done_base != 1) begin
            bad++;
            $display("FAIL frst_counts: samples=%0d done=%0d required %0d and 1",
                     got.size() - f_base, done_cnt - f_done_base, NCH);
        end
        total++;
        if (got.size() >= f_base + int'(NCH) && got[f_base + NCH - 1].data !== words[NCH - 1]) begin
            bad++;
            $display("FAIL frst_last_word: got %h required %h", got[f_base + NCH - 1].data, words[NCH - 1]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        prep_frame(1'b0, 1'b1);
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0;
        while (rd_falls - rd_base < 5 && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        total++;
        if (rd_falls - rd_base < 5) begin
            bad++;
            $display("FAIL mid_reach_ch4: rd falls=%0d required 5", rd_falls - rd_base);
        end
        #2 reset_n_i = 1'b0;
        #1;
        total++;
        if ({cs_n_o, rd_n_o, adc_reset_o, convst_o, ready_o} !== 5'b11110) begin
            bad++;
            $display("FAIL mid_async: cs_n/rd_n/adc_reset/convst/ready=%b required 11110",
                     {cs_n_o, rd_n_o, adc_reset_o, convst_o, ready_o});
        end
        repeat (3) @(negedge clk_i);
        total++;
        if (got.size() - f_base != 4 || done_cnt - f_done_base != 0) begin
            bad++;
            $display("FAIL mid_outputs: samples=%0d done=%0d required 4 and 0",
                     got.size() - f_base, done_cnt - f_done_base);
        end
        reset_n_i = 1'b1;
        wait_adcrst(n);
        total++;
        if (n != int'(ARST) || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_adcrst: width=%0d ready=%b required %0d and 1", n, ready_o, ARST);
        end
    endtask

    task automatic test_back_to_back();
        bit stray;
        run_frame(3'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (got.size() - f_base != int'(NCH) || done_cnt - f_done_base != 1) begin
            bad++;
            $display("FAIL b2b_counts: samples=%0d done=%0d required %0d and 1",
                     got.size() - f_base, done_cnt - f_done_base, NCH);
        end
        stray = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (convst_o !== 1'b1 || ready_o !== 1'b1) stray = 1'b1;
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL b2b_ignored: start in DONE cycle began a frame, required ignored");
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_os_hold();
        test_timeout();
        test_frstdata();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(500_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
